// File: rtl/addsub_accumulator.sv
// Accumulator stage wrapped around a 32-bit adder/subtractor: ADD/SUB/LOAD/CLEAR
// commands in over valid/ready, the accumulated result out over valid/ready.

module adder_subtractor (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] sum_o
);
  // Subtraction as a + ~b + 1.
  assign sum_o = a_i + (b_i ^ {32{sub_i}}) + {31'b0, sub_i};
endmodule

module addsub_accumulator #(
  parameter bit          SATURATE = 1'b0,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] ACC_INIT = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_acc,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               sub;
  logic [31:0]        b_adj;
  logic [31:0]        sum;
  logic               ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
  end

  assign sub   = (op_q == OP_SUB);
  assign b_adj = data_q ^ {32{sub}};

  adder_subtractor u_addsub (
    .a_i   (acc_q),
    .b_i   (data_q),
    .sub_i (sub),
    .sum_o (sum)
  );

  // Signed overflow: operands of equal sign yielding a result of the other sign.
  assign ovf = (acc_q[31] == b_adj[31]) && (sum[31] != acc_q[31]);

  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (state_q == S_IDLE && in_valid) begin
      op_d   = in_op;
      data_d = in_data;
    end
    if (state_q == S_EXEC) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (op_q)
        OP_ADD, OP_SUB: begin
          acc_d = sum;
          if (SATURATE && ovf) acc_d = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          ovf_d = ovf_q | ovf;
        end
        OP_LOAD:  acc_d = data_q;
        OP_CLEAR: begin
          acc_d = ACC_INIT;
          ovf_d = 1'b0;
        end
        default:  acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      data_q <= 32'h0;
      acc_q  <= ACC_INIT;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      data_q <= data_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_acc    = acc_q;
  assign ovf_sticky = ovf_q;
  assign op_count   = cnt_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Drives a wrapping (CNT_W=16) and a saturating (CNT_W=2) accumulator with the same
// command stream and compares both against a signed-arithmetic reference model.

module tb_addsub_accumulator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b1;

  logic        in_ready_w, out_valid_w, ovf_w;
  logic [31:0] acc_w;
  logic [15:0] cnt_w;
  logic        in_ready_s, out_valid_s, ovf_s;
  logic [31:0] acc_s;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc_w, m_acc_s;
  logic        m_ovf_w, m_ovf_s;
  int          m_cnt;

  always #5 clk = ~clk;

  addsub_accumulator #(.SATURATE(1'b0), .CNT_W(16)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_acc(acc_w), .ovf_sticky(ovf_w), .op_count(cnt_w)
  );

  addsub_accumulator #(.SATURATE(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_acc(acc_s), .ovf_sticky(ovf_s), .op_count(cnt_s)
  );

  task automatic model_reset();
    m_acc_w = 32'h0; m_acc_s = 32'h0;
    m_ovf_w = 1'b0;  m_ovf_s = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic arith(input logic [31:0] a, input logic [31:0] d, input bit is_sub,
                       input bit sat, output logic [31:0] res, output bit ovf);
    longint r;
    r = is_sub ? (longint'($signed(a)) - longint'($signed(d)))
               : (longint'($signed(a)) + longint'($signed(d)));
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    res = r[31:0];
    if (sat && ovf) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] r;
    bit          o;
    case (op)
      2'b00, 2'b01: begin
        arith(m_acc_w, d, op[0], 1'b0, r, o); m_acc_w = r; m_ovf_w = m_ovf_w | o;
        arith(m_acc_s, d, op[0], 1'b1, r, o); m_acc_s = r; m_ovf_s = m_ovf_s | o;
      end
      2'b10: begin m_acc_w = d; m_acc_s = d; end
      default: begin
        m_acc_w = 32'h0; m_acc_s = 32'h0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
      end
    endcase
    m_cnt++;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (acc_w !== m_acc_w || ovf_w !== m_ovf_w || cnt_w !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL %s wrap: acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b cnt=%0d",
               name, acc_w, ovf_w, cnt_w, m_acc_w, m_ovf_w, 16'(m_cnt));
    end
    checks++;
    if (acc_s !== m_acc_s || ovf_s !== m_ovf_s || cnt_s !== 2'(m_cnt)) begin
      errors++;
      $display("FAIL %s sat: acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b cnt=%0d",
               name, acc_s, ovf_s, cnt_s, m_acc_s, m_ovf_s, 2'(m_cnt));
    end
  endtask

  // One full transaction; dly = number of RESP cycles spent with out_ready low.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [31:0] d,
                        input int dly);
    logic [31:0] held_w, held_s;
    out_ready = (dly == 0);
    in_valid = 1'b1; in_op = op; in_data = d;
    checks++;
    if (in_ready_w !== 1'b1 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: in_ready=%b/%b required 1/1", name, in_ready_w, in_ready_s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    checks++;
    if (out_valid_w !== 1'b0 || in_ready_w !== 1'b0 || out_valid_s !== 1'b0) begin
      errors++;
      $display("FAIL %s exec: out_valid=%b in_ready=%b required 0 0", name, out_valid_w, in_ready_w);
    end
    @(posedge clk); #1;
    model_apply(op, d);
    checks++;
    if (out_valid_w !== 1'b1 || out_valid_s !== 1'b1 || in_ready_w !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_valid: out_valid=%b/%b in_ready=%b required 1/1 0",
               name, out_valid_w, out_valid_s, in_ready_w);
    end
    check_state(name);
    held_w = acc_w; held_s = acc_s;
    for (int i = 0; i < dly; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_op = 2'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid_w !== 1'b1 || acc_w !== held_w || acc_s !== held_s || in_ready_w !== 1'b0
          || cnt_w !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b acc=%h/%h in_ready=%b cnt=%0d required 1 %h/%h 0 %0d",
                 name, i, out_valid_w, acc_w, acc_s, in_ready_w, cnt_w, held_w, held_s, 16'(m_cnt));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL %s back_idle: in_ready=%b out_valid=%b required 1 0", name, in_ready_w, out_valid_w);
    end
    $display("txn %s op=%0d data=%h acc_w=%h acc_s=%h ovf=%b/%b cnt=%0d/%0d",
             name, op, d, acc_w, acc_s, ovf_w, ovf_s, cnt_w, cnt_s);
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (acc_w !== 32'h0 || out_valid_w !== 1'b0 || in_ready_w !== 1'b1 || ovf_w !== 1'b0 ||
        cnt_w !== 16'h0 || out_valid_s !== 1'b0 || cnt_s !== 2'h0) begin
      errors++;
      $display("FAIL reset: acc=%h valid=%b ready=%b ovf=%b cnt=%0d required 0 0 1 0 0",
               acc_w, out_valid_w, in_ready_w, ovf_w, cnt_w);
    end
  endtask

  task automatic test_add_sub();
    do_cmd("add5", 2'b00, 32'd5, 0);
    do_cmd("add7", 2'b00, 32'd7, 0);
    checks++;
    if (acc_w !== 32'd12 || cnt_w !== 16'd2) begin
      errors++;
      $display("FAIL add_total: acc=%h cnt=%0d required 0000000c 2", acc_w, cnt_w);
    end
    do_cmd("sub20", 2'b01, 32'd20, 0);
    checks++;
    if (acc_w !== 32'hFFFF_FFF8 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL sub20: acc=%h ovf=%b required fffffff8 0", acc_w, ovf_w);
    end
  endtask

  task automatic test_overflow();
    do_cmd("load_max", 2'b10, 32'h7FFF_FFFF, 0);
    do_cmd("add1", 2'b00, 32'd1, 0);
    checks++;
    if (acc_w !== 32'h8000_0000 || acc_s !== 32'h7FFF_FFFF || ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL pos_ovf: acc=%h/%h ovf=%b/%b required 80000000/7fffffff 1/1",
               acc_w, acc_s, ovf_w, ovf_s);
    end
    do_cmd("load_min", 2'b10, 32'h8000_0000, 0);
    do_cmd("sub1", 2'b01, 32'd1, 0);
    checks++;
    if (acc_w !== 32'h7FFF_FFFF || acc_s !== 32'h8000_0000 || ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL neg_ovf: acc=%h/%h ovf=%b/%b required 7fffffff/80000000 1/1",
               acc_w, acc_s, ovf_w, ovf_s);
    end
    do_cmd("clear", 2'b11, 32'hDEAD_BEEF, 0);
    checks++;
    if (acc_w !== 32'h0 || ovf_w !== 1'b0 || acc_s !== 32'h0 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL clear: acc=%h ovf=%b required 0 0", acc_w, ovf_w);
    end
  endtask

  task automatic test_backpressure();
    do_cmd("bp_add", 2'b00, 32'h1234_5678, 5);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (acc_w !== 32'h0 || cnt_w !== 16'h0 || out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: acc=%h cnt=%0d valid=%b ready=%b required 0 0 0 1",
               acc_w, cnt_w, out_valid_w, in_ready_w);
    end
    $display("txn reset_mid acc=%h cnt=%0d", acc_w, cnt_w);
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int i = 0; i < 4; i++) do_cmd("cnt", 2'($urandom), $urandom, 0);
    checks++;
    if (cnt_s !== 2'd0 || cnt_w !== 16'd4) begin
      errors++;
      $display("FAIL cnt_wrap4: cnt=%0d/%0d required 4/0", cnt_w, cnt_s);
    end
    do_cmd("cnt5", 2'b00, 32'd1, 0);
    checks++;
    if (cnt_s !== 2'd1) begin
      errors++;
      $display("FAIL cnt_wrap5: cnt=%0d required 1", cnt_s);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0:       d = 32'h7FFF_FFF0 + 32'($urandom_range(31));
        1:       d = 32'h8000_0000 + 32'($urandom_range(31));
        default: d = $urandom;
      endcase
      do_cmd("rand", 2'($urandom), d, $urandom_range(2));
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
